mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester arbiter in front of a single shared memory port
//   (memory_unit / BSRAM with combinational read data). Each accepted request
//   runs a fixed three-cycle transaction: grant (IDLE), memory access (ACCESS),
//   response (RESP). Ties are resolved round-robin, or with port 0 always
//   winning when MEM_ARB_FIXED_PRIORITY_EN is defined.
//
// Parameters
//   CORE          core index for debug reporting
//   DATA_WIDTH    requester / memory data width
//   ADDRESS_BITS  requester / memory address width
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   rN_read/rN_write             requester N (N=0,1) request, held until granted
//   rN_address, rN_wdata         requester N address and store data
//   rN_grant                     one-cycle pulse: request accepted
//   rN_valid, rN_rdata           one-cycle response pulse and its data
//   mem_read/mem_write           memory enables (only driven in ACCESS)
//   mem_address, mem_wdata       memory address and store data
//   mem_rdata                    combinational memory read data
//   busy                         high while the FSM is not in IDLE
//   report                       debug trace request (no effect on logic)
//
// Configuration macro: MEM_ARB_FIXED_PRIORITY_EN
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    r0_read,
  input  logic                    r0_write,
  input  logic [ADDRESS_BITS-1:0] r0_address,
  input  logic [DATA_WIDTH-1:0]   r0_wdata,
  output logic                    r0_grant,
  output logic                    r0_valid,
  output logic [DATA_WIDTH-1:0]   r0_rdata,
  input  logic                    r1_read,
  input  logic                    r1_write,
  input  logic [ADDRESS_BITS-1:0] r1_address,
  input  logic [DATA_WIDTH-1:0]   r1_wdata,
  output logic                    r1_grant,
  output logic                    r1_valid,
  output logic [DATA_WIDTH-1:0]   r1_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy,
  input  logic                    report
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic pend0, pend1, any_pend, win1;

  // The trace hook carries no functional meaning in hardware.
  logic unused_debug;
  assign unused_debug = report ^ (CORE != 0);

  assign pend0    = r0_read | r0_write;
  assign pend1    = r1_read | r1_write;
  assign any_pend = pend0 | pend1;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  // Port 1 only wins when port 0 is not asking.
  assign win1 = pend1 & ~pend0;
`else
  // last_grant_q holds the index of the port granted most recently; on a tie
  // the other port wins.
  logic last_grant_q, last_grant_d;
  assign win1 = pend1 & (~pend0 | ~last_grant_q);
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          owner_d = win1;
          rd_d    = win1 ? r1_read    : r0_read;
          wr_d    = win1 ? r1_write   : r0_write;
          addr_d  = win1 ? r1_address : r0_address;
          wdata_d = win1 ? r1_wdata   : r0_wdata;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
          last_grant_d = win1;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Read+write returns the store data directly so the response does not
        // depend on the memory's forwarding path; write-only returns zero.
        if (rd_q) begin
          rdata_d = wr_q ? wdata_q : mem_rdata;
        end else begin
          rdata_d = '0;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Every output is qualified with ~reset so that asserting reset mid
  // transaction suppresses the memory write and the response immediately.
  logic in_idle, in_access, in_resp;
  assign in_idle   = (state_q == IDLE)   & ~reset;
  assign in_access = (state_q == ACCESS) & ~reset;
  assign in_resp   = (state_q == RESP)   & ~reset;

  assign r0_grant = in_idle & any_pend & ~win1;
  assign r1_grant = in_idle & any_pend &  win1;

  assign r0_valid = in_resp & ~owner_q;
  assign r1_valid = in_resp &  owner_q;
  assign r0_rdata = r0_valid ? rdata_q : '0;
  assign r1_rdata = r1_valid ? rdata_q : '0;

  assign mem_read    = in_access & rd_q;
  assign mem_write   = in_access & wr_q;
  assign mem_address = in_access ? addr_q  : '0;
  assign mem_wdata   = in_access ? wdata_q : '0;

  assign busy = (state_q != IDLE) & ~reset;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [7:0]  r0_address, r1_address;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_grant, r0_valid, r1_grant, r1_valid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_read, mem_write;
  logic [7:0]  mem_address;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy;
  logic        report;

  mem_arbiter #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(8)) dut (
    .clock(clock), .reset(reset),
    .r0_read(r0_read), .r0_write(r0_write), .r0_address(r0_address),
    .r0_wdata(r0_wdata), .r0_grant(r0_grant), .r0_valid(r0_valid),
    .r0_rdata(r0_rdata),
    .r1_read(r1_read), .r1_write(r1_write), .r1_address(r1_address),
    .r1_wdata(r1_wdata), .r1_grant(r1_grant), .r1_valid(r1_valid),
    .r1_rdata(r1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .report(report)
  );

  always #5 clock = ~clock;

  // Shared memory model: combinational read with same-address write forwarding.
  logic [31:0] mem [256];
  assign mem_rdata = mem_write ? mem_wdata : mem[mem_address];
  always @(posedge clock) if (mem_write) mem[mem_address] <= mem_wdata;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
  } mem_t;
  typedef struct packed {
    logic        port;
    logic [31:0] d;
  } resp_t;

  logic  exp_grant[$];
  mem_t  exp_mem[$];
  resp_t exp_resp[$];
  int    gcyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_g = -10;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant, a memory
  // access or a response.
  always @(negedge clock) begin
    if (reset) begin
      gcyc.delete();
    end else begin
      if (r0_grant || r1_grant) begin
        check("grant_onehot", {63'd0, r0_grant & r1_grant}, 64'd0);
        if (exp_grant.size() == 0) flag("unexpected_grant", {62'd0, r1_grant, r0_grant});
        else begin
          logic eg;
          eg = exp_grant.pop_front();
          check("grant_port", {63'd0, r1_grant}, {63'd0, eg});
          $display("grant port=%0d cycle=%0d", r1_grant, cyc);
        end
        gcyc.push_back(cyc);
        last_g = cyc;
      end
      if (mem_read || mem_write) begin
        if (exp_mem.size() == 0) flag("unexpected_mem", {mem_read, mem_write, mem_address, mem_wdata});
        else begin
          mem_t em;
          em = exp_mem.pop_front();
          check("mem_access", {mem_read, mem_write, mem_address, mem_wdata}, em);
          check("mem_latency", cyc, last_g + 1);
          $display("mem rd=%0d wr=%0d addr=%0d wdata=%0d", mem_read, mem_write, mem_address, mem_wdata);
        end
      end
      if (r0_valid || r1_valid) begin
        check("valid_onehot", {63'd0, r0_valid & r1_valid}, 64'd0);
        if (exp_resp.size() == 0) flag("unexpected_valid", {62'd0, r1_valid, r0_valid});
        else begin
          resp_t er;
          er = exp_resp.pop_front();
          check("resp", {r1_valid, (r1_valid ? r1_rdata : r0_rdata)}, er);
          if (gcyc.size() == 0) flag("resp_no_grant", cyc);
          else check("resp_latency", cyc, gcyc.pop_front() + 2);
          $display("resp port=%0d rdata=%0d", r1_valid, r1_valid ? r1_rdata : r0_rdata);
        end
      end
    end
  end

  task automatic clear_all();
    r0_read = 0; r0_write = 0; r0_address = 0; r0_wdata = 0;
    r1_read = 0; r1_write = 0; r1_address = 0; r1_wdata = 0;
  endtask

  task automatic drive(input int port, input bit rd, input bit wr,
                       input logic [7:0] a, input logic [31:0] d);
    if (port == 0) begin r0_read = rd; r0_write = wr; r0_address = a; r0_wdata = d; end
    else begin r1_read = rd; r1_write = wr; r1_address = a; r1_wdata = d; end
  endtask

  task automatic wait_grant(input int port);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if ((port == 0) ? r0_grant : r1_grant) seen = 1;
    end
    if (!seen) flag("grant_timeout", port);
  endtask

  // One complete transaction; returns at the start of the next IDLE cycle.
  task automatic do_req(input int port, input bit rd, input bit wr,
                        input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata);
    exp_grant.push_back(port[0]);
    exp_mem.push_back('{rd: rd, wr: wr, a: a, d: d});
    exp_resp.push_back('{port: port[0], d: exp_rdata});
    drive(port, rd, wr, a, d);
    wait_grant(port);
    @(posedge clock); #1 clear_all();
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 0;
    report = 0;
    clear_all();
    reset = 1;
    // Requests present during reset must not leak to any output.
    r0_read = 1; r1_write = 1; r1_wdata = 32'h55;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outputs",
          {r0_grant, r1_grant, r0_valid, r1_valid, mem_read, mem_write, busy,
           mem_address, mem_wdata[23:0], r0_rdata[15:0]},
          64'd0);
    check("reset_rdata1", {32'd0, r1_rdata}, 64'd0);
    @(posedge clock); #1 reset = 0; clear_all();

    // Write then read back across ports.
    do_req(0, 0, 1, 8'd4, 32'd9, 32'd0);
    do_req(1, 1, 0, 8'd4, 32'd0, 32'd9);
    // Read+write forwards the store data; later read sees it.
    do_req(0, 1, 1, 8'd12, 32'd9, 32'd9);
    do_req(1, 1, 0, 8'd12, 32'd0, 32'd9);

    // Reset during ACCESS aborts the write and the response.
    exp_grant.push_back(1'b1);
    drive(1, 0, 1, 8'd8, 32'd5);
    wait_grant(1);
    @(posedge clock); #1 clear_all(); reset = 1;
    @(negedge clock);
    check("abort_mem_write", {63'd0, mem_write}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    check("abort_idle", {62'd0, busy, r1_valid}, 64'd0);
    @(posedge clock); #1;
    do_req(0, 1, 0, 8'd8, 32'd0, 32'd0);

    // A request pulsed during another port's ACCESS and dropped is ignored.
    exp_grant.push_back(1'b1);
    exp_mem.push_back('{rd: 1'b1, wr: 1'b0, a: 8'd8, d: 32'd0});
    exp_resp.push_back('{port: 1'b1, d: 32'd0});
    drive(1, 1, 0, 8'd8, 32'd0);
    wait_grant(1);
    @(posedge clock); #1 clear_all(); r0_read = 1; r0_address = 8'd4;
    @(posedge clock); #1 r0_read = 0;
    repeat (3) @(posedge clock);
    #1;

    // Continuous tie after reset.
    reset = 1;
    @(posedge clock); #1 reset = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      exp_grant.push_back(1'b0);
      exp_mem.push_back('{rd: 1'b1, wr: 1'b0, a: 8'd4, d: 32'd0});
      exp_resp.push_back('{port: 1'b0, d: 32'd9});
`else
      exp_grant.push_back(k[0]);
      exp_mem.push_back('{rd: 1'b1, wr: 1'b0, a: (k[0] ? 8'd8 : 8'd4), d: 32'd0});
      exp_resp.push_back('{port: k[0], d: (k[0] ? 32'd0 : 32'd9)});
`endif
    end
    drive(0, 1, 0, 8'd4, 32'd0);
    drive(1, 1, 0, 8'd8, 32'd0);
    begin
      int n = 0;
      int prev = -1;
      for (int i = 0; i < 40 && n < 4; i++) begin
        @(negedge clock);
        if (r0_grant || r1_grant) begin
          if (prev >= 0) check("grant_spacing", cyc - prev, 3);
          prev = cyc;
          n++;
        end
      end
      if (n < 4) flag("tie_grant_timeout", n);
    end
    @(posedge clock); #1 clear_all();
    repeat (3) @(posedge clock);
    #1;

    check("leftover_grants", exp_grant.size(), 0);
    check("leftover_mem", exp_mem.size(), 0);
    check("leftover_resp", exp_resp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
